// File: rtl/ldm_stm_seq.sv
// Block-transfer sequencer for LDM/STM: walks a 16-bit register list, one memory word per transfer,
// driving register-file selects and an optional base-register writeback.
module ldm_stm_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_load,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  output logic              busy,
  output logic              done,
  output logic [3:0]        sel_rd,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [3:0]        sel_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    LAST  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] WORD = {{(ADDR_W-3){1'b0}}, 3'b100};

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic                is_load_r;
  logic                up_r;
  logic                pre_r;
  logic                wb_r;
  logic [3:0]          base_reg_r;
  logic [15:0]         orig_list_r;
  logic [15:0]         list_r;
  logic [ADDR_W-1:0]   base_r;
  logic [3:0]          cur_r;
  logic [ADDR_W-1:0]   cur_addr_r;
  logic [ADDR_W-1:0]   final_r;
  logic                wr_en_r;
  logic [3:0]          sel_wr_r;
  logic [DATA_W-1:0]   wr_data_r;

  logic [4:0]          n_s;
  logic [ADDR_W-1:0]   four_n_s;
  logic [ADDR_W-1:0]   start_addr_s;
  logic [ADDR_W-1:0]   final_s;
  logic [15:0]         list_next_s;
  logic                xfer_s;
  logic                wb_hit_s;

  // Address arithmetic for SETUP and list bookkeeping for XFER.
  always_comb begin
    n_s          = popcount16(list_r);
    four_n_s     = {{(ADDR_W-7){1'b0}}, n_s, 2'b00};
    final_s      = up_r ? (base_r + four_n_s) : (base_r - four_n_s);
    list_next_s  = list_r & ~(16'd1 << cur_r);
    xfer_s       = (state_r == XFER);
    // A base register that is itself loaded keeps the loaded value.
    wb_hit_s     = wb_r & ~(is_load_r & orig_list_r[base_reg_r]);
    start_addr_s = base_r;
    case ({up_r, pre_r})
      2'b10:   start_addr_s = base_r;
      2'b11:   start_addr_s = base_r + WORD;
      2'b00:   start_addr_s = base_r - four_n_s + WORD;
      2'b01:   start_addr_s = base_r - four_n_s;
      default: start_addr_s = base_r;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (reg_list != 16'd0) ? SETUP : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: state_s = XFER;
      XFER: begin
        if (mem_ack && (list_next_s == 16'd0)) begin
          state_s = LAST;
        end else begin
          state_s = XFER;
        end
      end
      LAST:    state_s = WB;
      WB:      state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latching, transfer walk and register-file write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_load_r   <= 1'b0;
      up_r        <= 1'b0;
      pre_r       <= 1'b0;
      wb_r        <= 1'b0;
      base_reg_r  <= 4'd0;
      orig_list_r <= 16'd0;
      list_r      <= 16'd0;
      base_r      <= {ADDR_W{1'b0}};
      cur_r       <= 4'd0;
      cur_addr_r  <= {ADDR_W{1'b0}};
      final_r     <= {ADDR_W{1'b0}};
      wr_en_r     <= 1'b0;
      sel_wr_r    <= 4'd0;
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      wr_en_r   <= 1'b0;
      sel_wr_r  <= 4'd0;
      wr_data_r <= {DATA_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (start) begin
            is_load_r   <= is_load;
            up_r        <= up;
            pre_r       <= pre;
            wb_r        <= writeback;
            base_reg_r  <= base_reg;
            orig_list_r <= reg_list;
            list_r      <= reg_list;
            base_r      <= base_addr;
          end
        end
        SETUP: begin
          cur_addr_r <= start_addr_s;
          final_r    <= final_s;
          cur_r      <= lowest_set(list_r);
        end
        XFER: begin
          if (mem_ack) begin
            list_r     <= list_next_s;
            cur_addr_r <= cur_addr_r + WORD;
            cur_r      <= lowest_set(list_next_s);
            if (is_load_r) begin
              wr_en_r   <= 1'b1;
              sel_wr_r  <= cur_r;
              wr_data_r <= mem_rdata;
            end
          end
        end
        LAST: begin
          // Writeback is registered here so it appears during the WB cycle.
          if (wb_hit_s) begin
            wr_en_r   <= 1'b1;
            sel_wr_r  <= base_reg_r;
            wr_data_r <= final_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign mem_req   = xfer_s;
  assign mem_we    = xfer_s & ~is_load_r;
  assign mem_addr  = xfer_s ? cur_addr_r : {ADDR_W{1'b0}};
  assign sel_rd    = xfer_s ? cur_r : 4'd0;
  assign mem_wdata = xfer_s ? rd_data : {DATA_W{1'b0}};
  assign wr_en     = wr_en_r;
  assign sel_wr    = sel_wr_r;
  assign wr_data   = wr_data_r;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: a transaction-level model predicts memory accesses,
// register writes and completion cycle; a per-cycle monitor compares the DUT against it.
module tb_ldm_stm_seq;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          is_load;
  logic [15:0]   reg_list;
  logic [AW-1:0] base_addr;
  logic [3:0]    base_reg;
  logic          up;
  logic          pre;
  logic          writeback;
  logic          busy;
  logic          done;
  logic [3:0]    sel_rd;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [3:0]    sel_wr;
  logic [DW-1:0] wr_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] rf [16];
  logic [DW-1:0] memst [logic [AW-1:0]];
  int            stall_n = 0;
  logic          force_ack = 1'b0;
  int            wait_cnt = 0;

  logic [AW-1:0] exp_addr [$];
  logic          exp_we [$];
  logic [DW-1:0] exp_wdata [$];
  logic [3:0]    exp_sel [$];
  logic [DW-1:0] exp_wd [$];

  int            checks = 0;
  int            failures = 0;
  int            n_acks = 0;
  int            n_wr = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            got;

  ldm_stm_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_load(is_load),
    .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg), .up(up),
    .pre(pre), .writeback(writeback), .busy(busy), .done(done), .sel_rd(sel_rd),
    .rd_data(rd_data), .wr_en(wr_en), .sel_wr(sel_wr), .wr_data(wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign rd_data   = rf[sel_rd];
  assign mem_ack   = force_ack | (mem_req & (wait_cnt >= stall_n));
  assign mem_rdata = 32'hAAAA0000 + mem_addr;

  always @(posedge clock) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected transaction queues.
  task automatic monitor();
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_req_held", mem_req, 1'b1);
        chk("stall_addr_held", mem_addr, prev_addr);
      end
      if (mem_req && mem_ack) begin
        n_acks++;
        if (exp_addr.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_mem_access: got addr %0h expected none", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_addr[0]);
          chk("mem_we", mem_we, exp_we[0]);
          if (exp_we[0]) chk("mem_wdata", mem_wdata, exp_wdata[0]);
          void'(exp_addr.pop_front()); void'(exp_we.pop_front()); void'(exp_wdata.pop_front());
        end
        if (mem_we) memst[mem_addr] = mem_wdata;
      end
      if (wr_en) begin
        n_wr++;
        if (exp_sel.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_reg_write: got r%0d=%0h expected none", sel_wr, wr_data);
        end else begin
          chk("sel_wr", sel_wr, exp_sel[0]);
          chk("wr_data", wr_data, exp_wd[0]);
          void'(exp_sel.pop_front()); void'(exp_wd.pop_front());
        end
        rf[sel_wr] = wr_data;
      end
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
  endtask

  // Transaction-level model: addresses ascend from the lowest word of the block.
  task automatic build_expect(input logic [15:0] lst, input logic [AW-1:0] base, input logic u,
                              input logic p, input logic wb, input logic [3:0] br,
                              input logic ld, output int done_cyc);
    int n;
    int k;
    logic [AW-1:0] span, lo, a, fin;
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    span = 32'(4 * n);
    if (u) lo = p ? base + 32'd4 : base;
    else   lo = p ? base - span : base - span + 32'd4;
    fin = u ? base + span : base - span;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        a = lo + 32'(4 * k);
        exp_addr.push_back(a); exp_we.push_back(!ld); exp_wdata.push_back(rf[i]);
        if (ld) begin exp_sel.push_back(4'(i)); exp_wd.push_back(32'hAAAA0000 + a); end
        k++;
      end
    end
    if (n > 0 && wb && !(ld && lst[br])) begin
      exp_sel.push_back(br); exp_wd.push_back(fin);
    end
    done_cyc = (n == 0) ? 1 : n * (stall_n + 1) + 4;
  endtask

  task automatic run_op(input logic [15:0] lst, input logic [AW-1:0] base, input logic u,
                        input logic p, input logic wb, input logic [3:0] br,
                        input logic ld, input bit poke, output int got_cyc);
    int dc;
    build_expect(lst, base, u, p, wb, br, ld, dc);
    reg_list = lst; base_addr = base; up = u; pre = p; writeback = wb;
    base_reg = br; is_load = ld; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    got_cyc = 0;
    for (int k = 1; k <= 300 && got_cyc == 0; k++) begin
      tick();
      if (done) got_cyc = k;
      if (poke && k == 2) begin start = 1'b1; reg_list = 16'hFFFF; end
      if (poke && k == 3) begin start = 1'b0; reg_list = lst; end
    end
    chk("done_cycle", got_cyc, dc);
    tick();
    chk("done_one_pulse", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("mem_queue_drained", exp_addr.size(), 0);
    chk("wr_queue_drained", exp_sel.size(), 0);
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete(); exp_sel.delete(); exp_wd.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_sel_wr"}, sel_wr, 4'h0);
    chk({tag, "_wr_data"}, wr_data, 32'h0);
    chk({tag, "_sel_rd"}, sel_rd, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    reset_n = 1'b0; start = 1'b0; is_load = 1'b0; reg_list = 16'h0; base_addr = 32'h0;
    base_reg = 4'h0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    tick();

    // LDM ascending post-index, ack held high even outside XFER.
    force_ack = 1'b1; stall_n = 0;
    run_op(16'h0003, 32'h100, 1'b1, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, got);
    chk("ldm_done_lit", got, 6);
    chk("ldm_r0_lit", rf[0], 32'hAAAA0100);
    chk("ldm_r1_lit", rf[1], 32'hAAAA0104);
    chk("ldm_r13_lit", rf[13], 32'h108);
    force_ack = 1'b0;

    // STM descending pre-index.
    rf[0] = 32'h1; rf[4] = 32'h4; rf[15] = 32'hF;
    run_op(16'h8011, 32'h200, 1'b0, 1'b1, 1'b1, 4'd13, 1'b0, 1'b0, got);
    chk("stm_1f4_lit", memst[32'h1F4], 32'h1);
    chk("stm_1f8_lit", memst[32'h1F8], 32'h4);
    chk("stm_1fc_lit", memst[32'h1FC], 32'hF);
    chk("stm_r13_lit", rf[13], 32'h1F4);

    // LDM with base register in list: loaded value wins.
    run_op(16'h0024, 32'h300, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, got);
    chk("ldmbase_r2_lit", rf[2], 32'hAAAA0300);
    chk("ldmbase_r5_lit", rf[5], 32'hAAAA0304);

    // LDM descending post-index.
    run_op(16'h000C, 32'h500, 1'b0, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, got);
    chk("ldmdec_r3_lit", rf[3], 32'hAAAA0500);
    chk("ldmdec_r13_lit", rf[13], 32'h4F8);

    // Stalled single transfer, with a start poked while busy.
    stall_n = 3;
    run_op(16'h0001, 32'h600, 1'b1, 1'b1, 1'b0, 4'd13, 1'b1, 1'b1, got);
    chk("stall_done_lit", got, 8);
    chk("stall_r0_lit", rf[0], 32'hAAAA0604);

    // Empty list.
    stall_n = 0;
    run_op(16'h0000, 32'h700, 1'b1, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, got);
    chk("empty_done_lit", got, 1);

    // Reset during the second of three transfers.
    stall_n = 2; n_acks = 0; n_wr = 0;
    build_expect(16'h0007, 32'h700, 1'b1, 1'b0, 1'b1, 4'd13, 1'b1, got);
    reg_list = 16'h0007; base_addr = 32'h700; up = 1'b1; pre = 1'b0; writeback = 1'b1;
    base_reg = 4'd13; is_load = 1'b1; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (n_acks == 1 && n_wr == 1 && mem_req) break;
    end
    chk("reset_point_acks", n_acks, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete(); exp_sel.delete(); exp_wd.delete();
    for (int k = 0; k < 3; k++) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("after_reset_idle", busy, 1'b0);
    chk("after_reset_writes", n_wr, 1);

    // Normal operation after the abort.
    stall_n = 0;
    run_op(16'h0003, 32'h800, 1'b1, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, got);
    chk("post_reset_done_lit", got, 6);
    chk("post_reset_r1_lit", rf[1], 32'hAAAA0804);
    chk("post_reset_r13_lit", rf[13], 32'h808);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
